// File: rtl/prefetch_unit_pkg.sv
// Shared constants for the instruction prefetch slice.
//   TX_CMD_BITS       : width of the TX link command header
//   TX_HEADER_READ_16 : header for a single 16-bit word read
//   DEFAULT_PC_BITS   : program counter / instruction word width
//   DEFAULT_NSHIFT    : bits moved per serial cycle
//   SERIAL_CYCLES     : serial cycles needed to move one full word
package prefetch_unit_pkg;

  localparam int TX_CMD_BITS = 4;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 4'h5;

  localparam int DEFAULT_PC_BITS = 16;
  localparam int DEFAULT_NSHIFT  = 2;
  localparam int SERIAL_CYCLES   = DEFAULT_PC_BITS / DEFAULT_NSHIFT;

endpackage

// File: rtl/prefetch_queue.sv
// Circular instruction word buffer.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empty the queue (pointers back to slot 0)
//   push       : write push_data at the tail
//   pop        : retire the head word
//   shift_head : shift the head word right by NSHIFT in place, zero fill
//   head_word  : current head word (valid when count != 0)
//   count      : number of words held, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module prefetch_queue #(
  parameter int WORD_BITS = 16,
  parameter int DEPTH     = 2,
  parameter int NSHIFT    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WORD_BITS-1:0]     push_data,
  input  logic                     pop,
  input  logic                     shift_head,
  output logic [WORD_BITS-1:0]     head_word,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]  head;
  logic [PTR_BITS-1:0]  tail;

  // NOTE: the storage array has no reset; count==0 already marks every slot
  // as invalid, and leaving it unreset lets it map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
    // The caller only shifts a valid head, so this never targets the slot
    // being pushed in the same cycle.
    if (shift_head) mem[head] <= mem[head] >> NSHIFT;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_BITS'(1);
      if (pop)  head <= head + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_word = mem[head];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: owns the program counter, issues word reads on
// the TX link, collects serial replies into a small queue and feeds the
// decoder (whole head word) and scheduler (imm16, NSHIFT bits per cycle).
//   clk, reset            : clock, synchronous active-high reset
//   block_prefetch        : hold off new fetch reads
//   write_pc_now          : during ext_pc_next, load PC bits from pc_serial_in
//   ext_pc_next           : rotate PC right by NSHIFT (serial read/write)
//   comp_counter          : scheduler serial cycle index 0..7
//   prefetch_idle         : nothing requested, sending or outstanding
//   pc_serial_out         : PC low bits for the serial port
//   pc_serial_in          : new PC bits from the ALU
//   tx_command_valid/...  : fetch request handshake, serial address, LSB first
//   rx_fetch_valid/done   : reply strobes, rx_pins carries data LSB first
//   inst_word/inst_valid  : queue head for the decoder, inst_consume pops it
//   load_imm16 ...        : imm16 delivery by in-place shifting of the head
// The PC always addresses the queue head word, so the next fetch address is
// PC + 2*count.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int NSHIFT      = DEFAULT_NSHIFT,
  parameter int PC_BITS     = DEFAULT_PC_BITS,
  parameter int QUEUE_WORDS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   block_prefetch,
  input  logic                   write_pc_now,
  input  logic                   ext_pc_next,
  input  logic [2:0]             comp_counter,
  output logic                   prefetch_idle,
  output logic [NSHIFT-1:0]      pc_serial_out,
  input  logic [NSHIFT-1:0]      pc_serial_in,
  output logic                   tx_command_valid,
  output logic [TX_CMD_BITS-1:0] tx_command,
  input  logic                   tx_command_started,
  output logic [NSHIFT-1:0]      tx_data,
  input  logic                   tx_data_next,
  input  logic                   rx_fetch_valid,
  input  logic                   rx_fetch_done,
  input  logic [NSHIFT-1:0]      rx_pins,
  output logic [PC_BITS-1:0]     inst_word,
  output logic                   inst_valid,
  input  logic                   inst_consume,
  input  logic                   load_imm16,
  output logic                   imm16_loaded,
  output logic [NSHIFT-1:0]      imm_data_out,
  input  logic                   next_imm_data
);

  localparam int SHIFT_CYCLES = PC_BITS / NSHIFT;
  localparam int CNT_BITS     = $clog2(SHIFT_CYCLES);
  localparam int QCNT_BITS    = $clog2(QUEUE_WORDS) + 1;
  localparam logic [CNT_BITS-1:0]  LAST_SHIFT = CNT_BITS'(SHIFT_CYCLES - 1);
  localparam logic [QCNT_BITS-1:0] QUEUE_FULL = QCNT_BITS'(QUEUE_WORDS);

  logic [PC_BITS-1:0]        pc;
  logic [PC_BITS-1:0]        addr_sr;
  logic [PC_BITS-1:0]        fetch_addr;
  logic [PC_BITS-1:0]        head_word;
  logic [PC_BITS-1:0]        rx_word;
  // Only the upper bits of the reply shifter are ever kept; the lowest
  // group would be shifted out on the next reply cycle anyway.
  logic [PC_BITS-NSHIFT-1:0] fill_sr;
  logic                      outstanding;
  logic                      sending;
  logic [CNT_BITS-1:0]       tx_cnt;
  logic [CNT_BITS-1:0]       imm_shift_cnt;
  logic [QCNT_BITS-1:0]      q_count;
  logic [NSHIFT-1:0]         pc_in_bits;
  logic                      issue;
  logic                      start;
  logic                      rx_take;
  logic                      rx_push;
  logic                      shift_head;
  logic                      imm_last;
  logic                      pop;
  logic                      flush;

  // Never start a read while the PC is being rotated: the address would be
  // computed from a half-rotated PC.
  assign issue = !block_prefetch && !outstanding && !sending &&
                 (q_count < QUEUE_FULL) && !ext_pc_next;
  assign start      = issue && tx_command_started;
  assign fetch_addr = pc + (PC_BITS'(q_count) << 1);

  // Replies after a reset have outstanding==0 and are dropped here.
  assign rx_take  = outstanding && rx_fetch_valid;
  assign rx_push  = outstanding && rx_fetch_done;
  assign rx_word  = {rx_pins, fill_sr};

  assign shift_head = next_imm_data && inst_valid;
  assign imm_last   = (imm_shift_cnt == LAST_SHIFT);
  assign pop        = (inst_consume && inst_valid) || (shift_head && imm_last);

  // A full serial PC write ends at serial cycle 7: the queued words belong
  // to the old PC, and the scheduler itself issues the first read at the
  // new PC, so we wait for that reply.
  assign flush      = ext_pc_next && write_pc_now && (comp_counter == 3'd7);
  assign pc_in_bits = write_pc_now ? pc_serial_in : pc[NSHIFT-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= '0;
      addr_sr       <= '0;
      fill_sr       <= '0;
      outstanding   <= 1'b0;
      sending       <= 1'b0;
      tx_cnt        <= '0;
      imm_shift_cnt <= '0;
    end else begin
      if (ext_pc_next) pc <= {pc_in_bits, pc[PC_BITS-1:NSHIFT]};
      else if (pop)    pc <= pc + PC_BITS'(2);

      if (start) begin
        addr_sr     <= fetch_addr;
        sending     <= 1'b1;
        outstanding <= 1'b1;
        tx_cnt      <= '0;
      end else if (sending && tx_data_next) begin
        addr_sr <= addr_sr >> NSHIFT;
        tx_cnt  <= tx_cnt + 1'b1;
        if (tx_cnt == LAST_SHIFT) sending <= 1'b0;
      end

      if (rx_take) fill_sr <= rx_word[PC_BITS-1:NSHIFT];
      if (rx_push) outstanding <= 1'b0;

      if (shift_head) imm_shift_cnt <= imm_last ? '0 : imm_shift_cnt + 1'b1;

      if (flush) begin
        outstanding   <= 1'b1;
        sending       <= 1'b0;
        imm_shift_cnt <= '0;
      end
    end
  end

  prefetch_queue #(
    .WORD_BITS (PC_BITS),
    .DEPTH     (QUEUE_WORDS),
    .NSHIFT    (NSHIFT)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (rx_push),
    .push_data  (rx_word),
    .pop        (pop),
    .shift_head (shift_head),
    .head_word  (head_word),
    .count      (q_count)
  );

  assign tx_command_valid = issue;
  assign tx_command       = TX_HEADER_READ_16;
  assign tx_data          = addr_sr[NSHIFT-1:0];
  assign prefetch_idle    = !issue && !sending && !outstanding;
  assign pc_serial_out    = pc[NSHIFT-1:0];
  assign inst_word        = head_word;
  assign inst_valid       = (q_count != '0);
  assign imm16_loaded     = load_imm16 && inst_valid;
  assign imm_data_out     = head_word[NSHIFT-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit. Reply words and fetch addresses are
// pushed to scoreboard queues when stimulus is driven and popped when the
// DUT presents them; a small PC/count model predicts fetch addresses.
module tb_prefetch_unit;
  import prefetch_unit_pkg::*;

  localparam int NSHIFT      = 2;
  localparam int PC_BITS     = 16;
  localparam int QUEUE_WORDS = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   block_prefetch;
  logic                   write_pc_now;
  logic                   ext_pc_next;
  logic [2:0]             comp_counter;
  logic                   prefetch_idle;
  logic [NSHIFT-1:0]      pc_serial_out;
  logic [NSHIFT-1:0]      pc_serial_in;
  logic                   tx_command_valid;
  logic [TX_CMD_BITS-1:0] tx_command;
  logic                   tx_command_started;
  logic [NSHIFT-1:0]      tx_data;
  logic                   tx_data_next;
  logic                   rx_fetch_valid;
  logic                   rx_fetch_done;
  logic [NSHIFT-1:0]      rx_pins;
  logic [PC_BITS-1:0]     inst_word;
  logic                   inst_valid;
  logic                   inst_consume;
  logic                   load_imm16;
  logic                   imm16_loaded;
  logic [NSHIFT-1:0]      imm_data_out;
  logic                   next_imm_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_word_q [$];
  logic [15:0] exp_addr_q [$];
  logic [15:0] model_pc;
  int          model_count;

  always #5 clk = ~clk;

  prefetch_unit #(
    .NSHIFT      (NSHIFT),
    .PC_BITS     (PC_BITS),
    .QUEUE_WORDS (QUEUE_WORDS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .block_prefetch     (block_prefetch),
    .write_pc_now       (write_pc_now),
    .ext_pc_next        (ext_pc_next),
    .comp_counter       (comp_counter),
    .prefetch_idle      (prefetch_idle),
    .pc_serial_out      (pc_serial_out),
    .pc_serial_in       (pc_serial_in),
    .tx_command_valid   (tx_command_valid),
    .tx_command         (tx_command),
    .tx_command_started (tx_command_started),
    .tx_data            (tx_data),
    .tx_data_next       (tx_data_next),
    .rx_fetch_valid     (rx_fetch_valid),
    .rx_fetch_done      (rx_fetch_done),
    .rx_pins            (rx_pins),
    .inst_word          (inst_word),
    .inst_valid         (inst_valid),
    .inst_consume       (inst_consume),
    .load_imm16         (load_imm16),
    .imm16_loaded       (imm16_loaded),
    .imm_data_out       (imm_data_out),
    .next_imm_data      (next_imm_data)
  );

  // Protocol rules the scheduler must obey.
  assert property (@(posedge clk) disable iff (reset) inst_consume |-> inst_valid);
  assert property (@(posedge clk) disable iff (reset)
                   $onehot0({ext_pc_next, inst_consume, next_imm_data}));
  assert property (@(posedge clk) disable iff (reset) ext_pc_next |-> prefetch_idle);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    write_pc_now       = 1'b0;
    ext_pc_next        = 1'b0;
    comp_counter       = 3'd0;
    pc_serial_in       = '0;
    tx_command_started = 1'b0;
    tx_data_next       = 1'b0;
    rx_fetch_valid     = 1'b0;
    rx_fetch_done      = 1'b0;
    rx_pins            = '0;
    inst_consume       = 1'b0;
    load_imm16         = 1'b0;
    next_imm_data      = 1'b0;
  endtask

  task automatic issue_fetch(input int block_at);
    bit          ok;
    logic [15:0] a;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (tx_command_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: tx_command_valid=%b after 20 cycles, required 1", tx_command_valid);
      return;
    end
    checks++;
    if (tx_command !== TX_HEADER_READ_16) begin
      errors++;
      $display("FAIL tx_command: got %h expected %h", tx_command, TX_HEADER_READ_16);
    end
    exp_addr_q.push_back(model_pc + 16'(2 * model_count));
    tx_command_started = 1'b1;
    tick();
    tx_command_started = 1'b0;
    a = exp_addr_q.pop_front();
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      if (i == block_at) block_prefetch = 1'b1;
      #0;
      checks++;
      if (tx_data !== a[2*i +: 2]) begin
        errors++;
        $display("FAIL tx_data[%0d] addr %h: got %0d expected %0d", i, a, tx_data, a[2*i +: 2]);
      end
      tx_data_next = 1'b1;
      tick();
      tx_data_next = 1'b0;
    end
    checks++;
    if (tx_command_valid !== 1'b0 || prefetch_idle !== 1'b0) begin
      errors++;
      $display("FAIL after_send: valid=%b idle=%b expected valid=0 idle=0", tx_command_valid, prefetch_idle);
    end
  endtask

  task automatic send_reply(input logic [15:0] w);
    exp_word_q.push_back(w);
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      rx_fetch_valid = 1'b1;
      rx_pins        = w[2*i +: 2];
      rx_fetch_done  = (i == SERIAL_CYCLES - 1);
      tick();
    end
    rx_fetch_valid = 1'b0;
    rx_fetch_done  = 1'b0;
    rx_pins        = '0;
    model_count++;
    checks++;
    if (inst_valid !== 1'b1 || inst_word !== exp_word_q[0]) begin
      errors++;
      $display("FAIL reply_head: valid=%b word=%h expected valid=1 word=%h", inst_valid, inst_word, exp_word_q[0]);
    end
  endtask

  task automatic consume_head();
    logic [15:0] e;
    checks++;
    if (exp_word_q.size() == 0) begin
      errors++;
      $display("FAIL consume_scoreboard: no expected word, inst_valid=%b", inst_valid);
      return;
    end
    e = exp_word_q.pop_front();
    if (inst_valid !== 1'b1 || inst_word !== e) begin
      errors++;
      $display("FAIL consume_word: valid=%b word=%h expected valid=1 word=%h", inst_valid, inst_word, e);
      if (inst_valid !== 1'b1) return;
    end
    inst_consume = 1'b1;
    tick();
    inst_consume = 1'b0;
    model_pc = model_pc + 16'd2;
    model_count--;
  endtask

  task automatic write_pc(input logic [15:0] v);
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      ext_pc_next  = 1'b1;
      write_pc_now = 1'b1;
      pc_serial_in = v[2*i +: 2];
      comp_counter = 3'(i);
      tick();
    end
    clear_inputs();
    model_pc    = v;
    model_count = 0;
    exp_word_q.delete();
    checks++;
    if (inst_valid !== 1'b0 || prefetch_idle !== 1'b0 || tx_command_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: valid=%b idle=%b tx_valid=%b expected 0 0 0", inst_valid, prefetch_idle, tx_command_valid);
    end
  endtask

  task automatic read_pc();
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      checks++;
      if (pc_serial_out !== model_pc[2*i +: 2]) begin
        errors++;
        $display("FAIL pc_serial_out[%0d] pc %h: got %0d expected %0d", i, model_pc, pc_serial_out, model_pc[2*i +: 2]);
      end
      ext_pc_next  = 1'b1;
      write_pc_now = 1'b0;
      comp_counter = 3'(i);
      tick();
    end
    clear_inputs();
    checks++;
    if (pc_serial_out !== model_pc[1:0] || prefetch_idle !== 1'b1) begin
      errors++;
      $display("FAIL pc_after_rotate: out=%0d idle=%b expected out=%0d idle=1", pc_serial_out, prefetch_idle, model_pc[1:0]);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    block_prefetch = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset      = 1'b0;
    load_imm16 = 1'b1;
    #0;
    checks++;
    if (tx_command_valid !== 1'b0 || inst_valid !== 1'b0 || imm16_loaded !== 1'b0 ||
        prefetch_idle !== 1'b1 || pc_serial_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: tx_valid=%b inst_valid=%b imm=%b idle=%b pc_out=%0d expected 0 0 0 1 0",
               tx_command_valid, inst_valid, imm16_loaded, prefetch_idle, pc_serial_out);
    end
    load_imm16     = 1'b0;
    block_prefetch = 1'b0;
    #1;
    checks++;
    if (tx_command_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_issue: tx_command_valid=%b expected 1", tx_command_valid);
    end
    model_pc    = 16'h0000;
    model_count = 0;
    exp_word_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_fetch_basic();
    int bad;
    issue_fetch(-1);
    send_reply(16'h1234);
    issue_fetch(-1);
    send_reply(16'h5678);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_command_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_no_issue: tx_command_valid high %0d cycles, expected 0", bad);
    end
  endtask

  task automatic test_consume();
    consume_head();
    issue_fetch(-1);
    send_reply(16'h9ABC);
    consume_head();
    consume_head();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: inst_valid=%b expected 0", inst_valid);
    end
  endtask

  task automatic test_imm16();
    logic [15:0] w;
    issue_fetch(-1);
    send_reply(16'hABCD);
    w = exp_word_q.pop_front();
    load_imm16 = 1'b1;
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      #0;
      checks++;
      if (imm16_loaded !== 1'b1 || imm_data_out !== w[2*i +: 2]) begin
        errors++;
        $display("FAIL imm_data[%0d]: loaded=%b data=%0d expected loaded=1 data=%0d", i, imm16_loaded, imm_data_out, w[2*i +: 2]);
      end
      next_imm_data = 1'b1;
      tick();
      next_imm_data = 1'b0;
    end
    model_pc = model_pc + 16'd2;
    model_count--;
    checks++;
    if (inst_valid !== 1'b0 || imm16_loaded !== 1'b0) begin
      errors++;
      $display("FAIL imm_pop: inst_valid=%b loaded=%b expected 0 0", inst_valid, imm16_loaded);
    end
    load_imm16 = 1'b0;
  endtask

  task automatic test_block_prefetch();
    int bad;
    issue_fetch(3);
    send_reply(16'h0F0F);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_command_valid !== 1'b0 || prefetch_idle !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL blocked: %0d cycles with tx_valid=1 or idle=0, expected none", bad);
    end
    block_prefetch = 1'b0;
    #1;
    checks++;
    if (tx_command_valid !== 1'b1) begin
      errors++;
      $display("FAIL unblock: tx_command_valid=%b expected 1", tx_command_valid);
    end
    block_prefetch = 1'b1;
    #1;
  endtask

  task automatic test_serial_pc();
    write_pc(16'h00F0);
    send_reply(16'h1111);
    read_pc();
    write_pc(16'h8000);
    send_reply(16'h2222);
    block_prefetch = 1'b0;
    issue_fetch(-1);
    send_reply(16'h3333);
    consume_head();
    consume_head();
    block_prefetch = 1'b1;
    #1;
  endtask

  task automatic test_pc_wrap();
    write_pc(16'hFFFE);
    send_reply(16'h4444);
    consume_head();
    read_pc();
  endtask

  task automatic test_reset_mid_rx();
    logic [15:0] w;
    w = 16'hBEEF;
    block_prefetch = 1'b0;
    issue_fetch(-1);
    for (int i = 0; i < SERIAL_CYCLES; i++) begin
      if (i == 3) begin
        reset          = 1'b1;
        block_prefetch = 1'b1;
      end
      if (i == 4) reset = 1'b0;
      rx_fetch_valid = 1'b1;
      rx_pins        = w[2*i +: 2];
      rx_fetch_done  = (i == SERIAL_CYCLES - 1);
      tick();
    end
    clear_inputs();
    model_pc    = 16'h0000;
    model_count = 0;
    exp_word_q.delete();
    checks++;
    if (inst_valid !== 1'b0 || prefetch_idle !== 1'b1 || pc_serial_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_rx: inst_valid=%b idle=%b pc_out=%0d expected 0 1 0", inst_valid, prefetch_idle, pc_serial_out);
    end
    read_pc();
    block_prefetch = 1'b0;
    issue_fetch(-1);
    send_reply(16'h5555);
    consume_head();
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_consume();
    test_imm16();
    test_block_prefetch();
    test_serial_pc();
    test_pc_wrap();
    test_reset_mid_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
